// File: rtl/instr_memory.sv
// instr_memory -- instruction store with a fixed-latency fetch handshake.
//
// Fetch side: a request is accepted only in IDLE. The word (or NOP_WORD on
// a misaligned / out-of-range pc) is registered on the edge entering RESP.
// o_awk is high for exactly that one RESP cycle, LATENCY cycles after the
// acceptance edge. One fetch can be outstanding at a time.
// Load side: word writes are accepted in any state. Misaligned or
// out-of-range writes are dropped.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (memory is not cleared)
//   i_pc                  fetch byte address, captured at acceptance
//   i_instruction_request fetch request
//   i_wr_en/addr/data     program-load write port
//   o_instruction         registered fetched word, held until the next RESP
//   o_awk                 one-cycle fetch acknowledge
//   o_fault               registered fault flag, valid with o_awk
//   o_busy                high in WAIT and RESP
module instr_memory #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                LATENCY  = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h00000013)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_pc,
    input  logic              i_instruction_request,
    input  logic              i_wr_en,
    input  logic [31:0]       i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_instruction,
    output logic              o_awk,
    output logic              o_fault,
    output logic              o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] CNT_INIT = (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [31:0]       pc_q;
    logic [31:0]       rd_pc;
    logic              rd_fault;
    logic              wr_ok;
    logic [DATA_W-1:0] mem [DEPTH];

    // With LATENCY=1 RESP is entered on the acceptance edge itself, before
    // pc_q holds the new pc, so the live i_pc is used while still in IDLE.
    assign rd_pc    = (state == IDLE) ? i_pc : pc_q;
    assign rd_fault = (|rd_pc[1:0]) || (|rd_pc[31:AW+2]);
    assign wr_ok    = i_wr_en && !(|i_wr_addr[1:0]) && !(|i_wr_addr[31:AW+2]);

    // Memory array: no reset so loaded programs survive a CPU reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok)
            mem[i_wr_addr[AW+1:2]] <= i_wr_data;
    end

    // State register, captured pc and registered response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            pc_q          <= 32'd0;
            o_instruction <= '0;
            o_fault       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && i_instruction_request)
                pc_q <= i_pc;
            // Read on the RESP-entry edge: a same-edge write is not seen.
            if (state_nxt == RESP) begin
                o_fault       <= rd_fault;
                o_instruction <= rd_fault ? NOP_WORD : mem[rd_pc[AW+1:2]];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (i_instruction_request) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 2'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 2'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        o_awk  = (state == RESP);
        o_busy = (state != IDLE);
    end

endmodule

// File: tb/tb_instr_memory.sv
// Directed bench for instr_memory: three instances (LATENCY 1/3/4, DEPTH 16)
// share the write bus and pc; each has its own request, LATENCY=4 has its
// own reset.
module tb_instr_memory;

    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rst4_n = 1'b0;
    logic [31:0]   pc = '0;
    logic          req1 = 1'b0, req3 = 1'b0, req4 = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] instr1, instr3, instr4;
    logic          awk1, awk3, awk4, fault1, fault3, fault4, busy1, busy3, busy4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_memory #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(1)) d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc), .i_instruction_request(req1),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_instruction(instr1), .o_awk(awk1), .o_fault(fault1), .o_busy(busy1));

    instr_memory #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(3)) d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc), .i_instruction_request(req3),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_instruction(instr3), .o_awk(awk3), .o_fault(fault3), .o_busy(busy3));

    instr_memory #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(4)) d4 (
        .i_clk(clk), .i_rst_n(rst4_n), .i_pc(pc), .i_instruction_request(req4),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_instruction(instr4), .o_awk(awk4), .o_fault(fault4), .o_busy(busy4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Single LATENCY=1 fetch: check ack cycle, then drop request and step.
    task automatic fetch1(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_w, input logic exp_f);
        pc = a; req1 = 1'b1;
        tick();
        req1 = 1'b0;
        chk({tag, "_awk"}, {31'd0, awk1}, 32'd1);
        chk({tag, "_data"}, instr1, exp_w);
        chk({tag, "_fault"}, {31'd0, fault1}, {31'd0, exp_f});
        tick();
    endtask

    logic seen;

    initial begin
        // Reset state (two clock edges with reset held).
        tick(); tick();
        chk("rst_awk",   {31'd0, awk1},  32'd0);
        chk("rst_busy",  {31'd0, busy1}, 32'd0);
        chk("rst_fault", {31'd0, fault1}, 32'd0);
        chk("rst_instr", instr1, 32'd0);
        rst_n = 1'b1; rst4_n = 1'b1;
        tick();

        // Program load.
        wr(32'h0,  32'hA0A0A0A0);
        wr(32'h4,  32'hB1B1B1B1);
        wr(32'h8,  32'hDEADBEEF);
        wr(32'h14, 32'h22222222);
        wr(32'h3C, 32'h0F0F0F0F);

        // LATENCY=1 basic fetch, busy in RESP, hold after RESP.
        pc = 32'h8; req1 = 1'b1;
        tick();
        req1 = 1'b0;
        chk("l1_awk",   {31'd0, awk1},  32'd1);
        chk("l1_busy",  {31'd0, busy1}, 32'd1);
        chk("l1_data",  instr1, 32'hDEADBEEF);
        chk("l1_fault", {31'd0, fault1}, 32'd0);
        tick();
        chk("l1_awk_off",  {31'd0, awk1},  32'd0);
        chk("l1_busy_off", {31'd0, busy1}, 32'd0);
        chk("l1_hold",     instr1, 32'hDEADBEEF);

        // Last valid word, then misaligned and out-of-range faults.
        fetch1("last", 32'h3C, 32'h0F0F0F0F, 1'b0);
        fetch1("misal", 32'h6, 32'h00000013, 1'b1);
        fetch1("oor", DEPTH * 4, 32'h00000013, 1'b1);

        // Write on the RESP-entry edge: old data returned, new on re-fetch.
        pc = 32'h14; req1 = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'h11111111;
        tick();
        req1 = 1'b0; wr_en = 1'b0;
        chk("rw_old", instr1, 32'h22222222);
        tick();
        fetch1("rw_new", 32'h14, 32'h11111111, 1'b0);

        // Misaligned write dropped.
        wr(32'h3, 32'hFFFFFFFF);
        fetch1("drop", 32'h0, 32'hA0A0A0A0, 1'b0);

        // LATENCY=3 with request held: acceptances at e0 and e4, acks e2 and e6.
        pc = 32'h0; req3 = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 0) pc = 32'h4;   // ignored while busy, taken at e4
            if (e == 4) pc = 32'h8;   // ignored, pc already captured
            chk($sformatf("l3_awk_e%0d", e), {31'd0, awk3},
                (e == 2 || e == 6) ? 32'd1 : 32'd0);
            if (e == 2) chk("l3_data0", instr3, 32'hA0A0A0A0);
            if (e == 6) chk("l3_data1", instr3, 32'hB1B1B1B1);
            if (e == 3) chk("l3_idle_gap", {31'd0, busy3}, 32'd0);
        end
        req3 = 1'b0;
        tick(); tick();

        // LATENCY=4: reset in WAIT abandons the fetch.
        pc = 32'h8; req4 = 1'b1;
        tick();
        req4 = 1'b0;
        tick();
        chk("l4_busy_wait", {31'd0, busy4}, 32'd1);
        #2 rst4_n = 1'b0;
        #1;
        chk("l4_rst_busy",  {31'd0, busy4}, 32'd0);
        chk("l4_rst_awk",   {31'd0, awk4},  32'd0);
        chk("l4_rst_instr", instr4, 32'd0);
        chk("l4_rst_fault", {31'd0, fault4}, 32'd0);
        tick();
        rst4_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (awk4) seen = 1'b1;
        end
        chk("l4_no_awk", {31'd0, seen}, 32'd0);

        // Fresh LATENCY=4 fetch: ack exactly on e3, memory intact.
        pc = 32'h8; req4 = 1'b1;
        tick();
        req4 = 1'b0;
        tick(); tick();
        chk("l4_awk_e2", {31'd0, awk4}, 32'd0);
        tick();
        chk("l4_awk_e3", {31'd0, awk4}, 32'd1);
        chk("l4_data",   instr4, 32'hDEADBEEF);
        tick();
        chk("l4_awk_e4", {31'd0, awk4}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
